// File: rtl/fir_rrc.sv
`default_nettype none
// ============================================================================
// Module      : fir_rrc
// Description : Fixed 21-tap root-raised-cosine FIR filter for 12-bit signed
//               baseband samples. Takes one sample per clock and produces one
//               filtered sample per clock. The output is registered.
//               Coefficients are Q1.15, symmetric, and sum to 32758.
//               The sum is formed at full precision, scaled by floor(/2^15),
//               and saturated to 12 bits.
// Ports       : clk  - sole clock, rising edge
//               rst  - synchronous active-high reset; clears history and out
//               in   - 12-bit signed input sample, taken every edge
//               out  - 12-bit signed filtered sample, registered
// Revision    : 1.0 - initial release
// ============================================================================
module fir_rrc (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [11:0] in,
    output logic signed [11:0] out
);

    localparam int c_taps = 21;
    localparam int c_half = 10;   // index of the centre tap
    localparam int c_accw = 34;   // 21 products of 28 bits plus headroom

    // Unique half of the symmetric coefficient set: c[k] = c[20-k].
    localparam logic signed [15:0] c_coef [0:c_half] = '{
        -16'sd120,  16'sd120,   16'sd344,   16'sd120,  -16'sd616,
        -16'sd1288, -16'sd872,  16'sd1288,  16'sd4746,  16'sd8000,
         16'sd9314
    };

    localparam logic signed [c_accw-1:0] c_max = 34'sd2047;
    localparam logic signed [c_accw-1:0] c_min = -34'sd2048;

    // r_dly[k] holds x[n-k] for k = 1..20. x[n] is the live input, so the
    // edge that samples a value also loads its filtered result.
    logic signed [11:0]       r_dly [1:c_taps-1];
    logic signed [11:0]       r_out;

    logic signed [11:0]       w_x   [0:c_taps-1];
    logic signed [c_accw-1:0] w_acc;
    logic signed [c_accw-1:0] w_scaled;
    logic signed [11:0]       w_sat;

    always_comb begin
        w_x[0] = in;
        for (int k = 1; k < c_taps; k++) begin
            w_x[k] = r_dly[k];
        end
    end

    // Symmetric pre-add: pair x[n-k] with x[n-20+k] and multiply once.
    always_comb begin
        w_acc = c_accw'(c_coef[c_half]) * c_accw'(w_x[c_half]);
        for (int k = 0; k < c_half; k++) begin
            w_acc = w_acc + c_accw'(c_coef[k])
                          * (c_accw'(w_x[k]) + c_accw'(w_x[c_taps-1-k]));
        end
    end

    // The arithmetic shift gives floor rounding toward minus infinity.
    always_comb begin
        w_scaled = w_acc >>> 15;
        if (w_scaled > c_max) begin
            w_sat = 12'sh7FF;
        end else if (w_scaled < c_min) begin
            w_sat = 12'sh800;
        end else begin
            w_sat = w_scaled[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < c_taps; k++) begin
                r_dly[k] <= '0;
            end
            r_out <= '0;
        end else begin
            r_dly[1] <= in;
            for (int k = 2; k < c_taps; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            r_out <= w_sat;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_fir_rrc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_rrc
// Description : Self-checking bench for fir_rrc. A behavioural convolution
//               model is compared against the DUT on every cycle. Directed
//               literal expectations pin both the DUT and the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_rrc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] din = 12'shAAA;
    logic signed [11:0] dout;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    int coef [0:20] = '{-120, 120, 344, 120, -616, -1288, -872, 1288, 4746,
                        8000, 9314, 8000, 4746, 1288, -872, -1288, -616, 120,
                        344, 120, -120};
    int imp  [0:21] = '{-8, 7, 21, 7, -39, -81, -55, 80, 296, 499, 581, 499,
                        296, 80, -55, -81, -39, 7, 21, 7, -8, 0};

    int     hist [0:20];
    int     exp_out = 0;
    longint acc;

    fir_rrc dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    always #5 clk = ~clk;

    function automatic int sat12(input longint v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return int'(v);
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    // Reference model: plain convolution over the last 21 accepted inputs.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 21; i++) hist[i] = 0;
            exp_out = 0;
        end else begin
            for (int i = 20; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(din);
            acc = 0;
            for (int k = 0; k < 21; k++) acc += longint'(coef[k]) * longint'(hist[k]);
            exp_out = sat12(acc >>> 15);
        end
    end

    always @(negedge clk) begin
        if (check_en) check("stream", dout, exp_out);
    end

    task automatic drive(input logic signed [11:0] v, input logic r);
        din = v;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(12'shAAA, 1'b1);
        check_en = 1'b1;

        repeat (500) drive(12'shAAA, 1'b1);
        check("rst_hold", dout, 0);

        repeat (500) drive(12'sd0, 1'b0);
        check("zero_in", dout, 0);

        // Impulse of amplitude 2047, then zeros.
        drive(12'sd2047, 1'b0);
        check("imp_0", dout, imp[0]);
        check("model_imp_0", exp_out, imp[0]);
        for (int i = 1; i < 22; i++) begin
            drive(12'sd0, 1'b0);
            check("imp", dout, imp[i]);
            check("model_imp", exp_out, imp[i]);
        end

        // Positive DC: 2047*32758/32768 = 2046.375, floored to 2046.
        repeat (21) drive(12'sd2047, 1'b0);
        repeat (50) begin
            drive(12'sd2047, 1'b0);
            check("dc_pos", dout, 2046);
        end

        // Negative DC: floor(-2047.375) = -2048.
        repeat (21) drive(12'sh800, 1'b0);
        repeat (50) begin
            drive(12'sh800, 1'b0);
            check("dc_neg", dout, -2048);
        end

        repeat (21) drive(12'sd0, 1'b0);

        // Worst case: x[n-k] takes the sign of c[k]; the oldest sample goes first.
        for (int j = 20; j >= 0; j--) begin
            drive((coef[j] >= 0) ? 12'sh7FF : 12'sh800, 1'b0);
        end
        check("sat_pos", dout, 2047);
        check("model_sat", exp_out, 2047);

        // Reset mid-stream, then an impulse must see an all-zero history.
        drive(12'sh555, 1'b1);
        check("rst_mid", dout, 0);
        drive(12'sd2047, 1'b0);
        check("post_rst_0", dout, -8);
        drive(12'sd0, 1'b0);
        check("post_rst_1", dout, 7);
        drive(12'sd0, 1'b0);
        check("post_rst_2", dout, 21);
        repeat (25) drive(12'sd0, 1'b0);
        check("post_rst_tail", dout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
